// File: rtl/db_arbiter.sv
// rtl/db_arbiter.sv - two-master data bus arbiter, round-robin fair, one slave locked per transaction
// Define DB_ARB_TIMEOUT_EN to build the slave-timeout abort (counter plus mN_err pulses).
`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T [2:0]
`endif
`ifndef MEM_ACCESS_NONE
`define MEM_ACCESS_NONE 3'd0
`endif
`ifndef MEM_LEN
`define MEM_LEN [1:0]
`endif

module db_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m0_dataOut,
    input  logic `MEM_ACCESS_T   m0_accessType,
    input  logic `MEM_LEN        m0_memLen,
    output logic [31:0]          m0_dataIn,
    output logic                 m0_ready,
    output logic                 m0_err,
    input  logic [31:0]          m1_addr,
    input  logic [31:0]          m1_dataOut,
    input  logic `MEM_ACCESS_T   m1_accessType,
    input  logic `MEM_LEN        m1_memLen,
    output logic [31:0]          m1_dataIn,
    output logic                 m1_ready,
    output logic                 m1_err,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_dataOut,
    output logic `MEM_ACCESS_T   s_accessType,
    output logic `MEM_LEN        s_memLen,
    input  logic [31:0]          s_dataIn,
    input  logic                 s_ready,
    output logic                 owner,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_M0 = 2'd1,
        BUSY_M1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   rr_q, rr_d;
    logic   owner_q, owner_d;
    logic   req0, req1;
    logic   busy_st;
    logic   sel;
    logic   active;
    logic   done;
    logic   timeout;

    // Requests are masked while in reset so the slave port idles immediately.
    always_comb begin
        req0    = res && (m0_accessType != `MEM_ACCESS_NONE);
        req1    = res && (m1_accessType != `MEM_ACCESS_NONE);
        busy_st = (state_q != IDLE);
    end

`ifdef DB_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts completed BUSY cycles without s_ready; idles at zero outside BUSY.
    always_comb begin
        timeout = busy_st && !s_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d   = (busy_st && !s_ready && !timeout) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES[0], CNT_W[0]};
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        sel     = owner_q;
        active  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    active  = 1'b1;
                    sel     = (req0 && req1) ? rr_q : req1;
                    owner_d = sel;
                    if (s_ready) begin
                        done = 1'b1;
                        rr_d = ~sel;
                    end else begin
                        state_d = sel ? BUSY_M1 : BUSY_M0;
                    end
                end
            end
            BUSY_M0, BUSY_M1: begin
                active = 1'b1;
                sel    = (state_q == BUSY_M1);
                if (s_ready || timeout) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    rr_d    = ~sel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    // An aborting transaction withdraws its request from the slave in the same cycle.
    always_comb begin
        s_addr       = '0;
        s_dataOut    = '0;
        s_accessType = `MEM_ACCESS_NONE;
        s_memLen     = '0;
        if (active && !timeout) begin
            if (sel) begin
                s_addr       = m1_addr;
                s_dataOut    = m1_dataOut;
                s_accessType = m1_accessType;
                s_memLen     = m1_memLen;
            end else begin
                s_addr       = m0_addr;
                s_dataOut    = m0_dataOut;
                s_accessType = m0_accessType;
                s_memLen     = m0_memLen;
            end
        end
        owner     = sel;
        busy      = busy_st;
        m0_ready  = done && !sel;
        m1_ready  = done && sel;
        m0_err    = timeout && !sel;
        m1_err    = timeout && sel;
        m0_dataIn = sel ? 32'd0 : s_dataIn;
        m1_dataIn = sel ? s_dataIn : 32'd0;
    end

endmodule

// File: tb/tb_db_arbiter.sv
// tb/tb_db_arbiter.sv - randomized bench for db_arbiter against a transaction-level reference model
`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T [2:0]
`endif
`ifndef MEM_ACCESS_NONE
`define MEM_ACCESS_NONE 3'd0
`endif
`ifndef MEM_LEN
`define MEM_LEN [1:0]
`endif

module tb_db_arbiter;

    localparam int TO = 4;
`ifdef DB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               res;
    logic [31:0]        m0_addr, m0_dataOut, m0_dataIn, m1_addr, m1_dataOut, m1_dataIn;
    logic `MEM_ACCESS_T m0_accessType, m1_accessType, s_accessType;
    logic `MEM_LEN      m0_memLen, m1_memLen, s_memLen;
    logic               m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0]        s_addr, s_dataOut, s_dataIn;
    logic               s_ready, owner, busy;

    db_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .res(res),
        .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_accessType(m0_accessType),
        .m0_memLen(m0_memLen), .m0_dataIn(m0_dataIn), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_accessType(m1_accessType),
        .m1_memLen(m1_memLen), .m1_dataIn(m1_dataIn), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_addr(s_addr), .s_dataOut(s_dataOut), .s_accessType(s_accessType),
        .s_memLen(s_memLen), .s_dataIn(s_dataIn), .s_ready(s_ready),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Master-side request state held by the bench.
    logic [31:0] addr_v [2];
    logic [31:0] dout_v [2];
    logic [2:0]  typ_v  [2];
    logic [1:0]  len_v  [2];
    bit          req_on [2];
    bit          renew  [2];

    // Reference model: which master holds the slave, how many BUSY cycles it has waited,
    // who wins the next tie, and who was last granted.
    int lock, waited, pref, last_owner;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        lock = -1; waited = 0; pref = 0; last_owner = 0;
    endtask

    task automatic start(input int n);
        addr_v[n] = $urandom;
        dout_v[n] = $urandom;
        typ_v[n]  = 3'($urandom_range(1, 7));
        len_v[n]  = 2'($urandom_range(0, 3));
        req_on[n] = 1'b1;
    endtask

    task automatic step(input bit rn, input bit sr, input logic [31:0] sd);
        int g, own;
        bit to, fw, fin;
        logic [31:0] e_addr, e_dout;
        logic [2:0]  e_typ;
        logic [1:0]  e_len;
        @(negedge clk);
        res           = rn;
        s_ready       = sr;
        s_dataIn      = sd;
        m0_addr       = addr_v[0];
        m0_dataOut    = dout_v[0];
        m0_accessType = req_on[0] ? typ_v[0] : `MEM_ACCESS_NONE;
        m0_memLen     = len_v[0];
        m1_addr       = addr_v[1];
        m1_dataOut    = dout_v[1];
        m1_accessType = req_on[1] ? typ_v[1] : `MEM_ACCESS_NONE;
        m1_memLen     = len_v[1];
        #1;
        if (!rn) model_reset();
        g = -1;
        if (lock >= 0)                           g = lock;
        else if (rn && req_on[0] && req_on[1])   g = pref;
        else if (rn && req_on[0])                g = 0;
        else if (rn && req_on[1])                g = 1;
        to  = TO_EN && (lock >= 0) && !sr && (waited + 1 == TO);
        fw  = (g >= 0) && !to;
        fin = (g >= 0) && (sr || to);
        own = (g >= 0) ? g : last_owner;
        e_addr = 0; e_dout = 0; e_typ = 0; e_len = 0;
        if (fw) begin
            e_addr = addr_v[g]; e_dout = dout_v[g]; e_typ = typ_v[g]; e_len = len_v[g];
        end
        chk("owner",    32'(owner),        32'(own));
        chk("busy",     32'(busy),         32'(lock >= 0));
        chk("s_addr",   s_addr,            e_addr);
        chk("s_dout",   s_dataOut,         e_dout);
        chk("s_type",   32'(s_accessType), 32'(e_typ));
        chk("s_len",    32'(s_memLen),     32'(e_len));
        chk("m0_ready", 32'(m0_ready),     32'(fin && g == 0));
        chk("m1_ready", 32'(m1_ready),     32'(fin && g == 1));
        chk("m0_err",   32'(m0_err),       32'(to && g == 0));
        chk("m1_err",   32'(m1_err),       32'(to && g == 1));
        chk("m0_din",   m0_dataIn,         (own == 0) ? sd : 32'd0);
        chk("m1_din",   m1_dataIn,         (own == 1) ? sd : 32'd0);
        last_owner = own;
        if (fin) begin
            lock = -1; waited = 0; pref = 1 - g;
        end else if (g >= 0) begin
            if (lock >= 0) waited++;
            else begin lock = g; waited = 0; end
        end
        for (int n = 0; n < 2; n++) begin
            if (fin && g == n) begin
                req_on[n] = 1'b0;
                if (renew[n]) start(n);
            end
        end
    endtask

    task automatic drain();
        renew[0] = 1'b0; renew[1] = 1'b0;
        for (int i = 0; i < 6 && (req_on[0] || req_on[1]); i++) step(1'b1, 1'b1, $urandom);
    endtask

    initial begin
        logic [31:0] m1a;
        int lock_wait;
        res = 1'b0; s_ready = 1'b0; s_dataIn = 0;
        m0_addr = 0; m0_dataOut = 0; m0_accessType = 0; m0_memLen = 0;
        m1_addr = 0; m1_dataOut = 0; m1_accessType = 0; m1_memLen = 0;
        req_on[0] = 0; req_on[1] = 0; renew[0] = 0; renew[1] = 0;
        model_reset();

        // Reset with both masters requesting: port must stay idle.
        start(0); start(1);
        step(1'b0, 1'b1, $urandom);
        step(1'b0, 1'b1, $urandom);

        // Contention from reset: m0 first, then strict alternation.
        renew[0] = 1'b1; renew[1] = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, $urandom);
        drain();

        // Single master, same-cycle completion.
        start(0);
        addr_v[0] = 32'h8000_0000; typ_v[0] = 3'd1;
        step(1'b1, 1'b1, 32'h1234_5678);
        chk("single_din", m0_dataIn, 32'h1234_5678);
        chk("single_rdy", 32'(m0_ready), 32'd1);
        step(1'b1, 1'b0, $urandom);

        // Lock: m1 holds the slave while m0 waits.
        lock_wait = TO_EN ? 3 : 5;
        start(1);
        m1a = addr_v[1];
        for (int i = 0; i <= lock_wait; i++) begin
            step(1'b1, (i == lock_wait), $urandom);
            chk("lock_addr", s_addr, m1a);
            if (i == 0) start(0);
        end
        step(1'b1, 1'b1, $urandom);
        chk("lock_next", 32'(owner), 32'd0);
        drain();

`ifdef DB_ARB_TIMEOUT_EN
        // Timeout on the 4th BUSY cycle, then the boundary where s_ready wins.
        start(0); typ_v[0] = 3'd2;
        step(1'b1, 1'b0, $urandom);
        for (int i = 1; i <= TO; i++) step(1'b1, 1'b0, $urandom);
        chk("to_err",  32'(m0_err),       32'd1);
        chk("to_type", 32'(s_accessType), 32'd0);
        step(1'b1, 1'b0, $urandom);
        start(0);
        step(1'b1, 1'b0, $urandom);
        for (int i = 1; i < TO; i++) step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, $urandom);
        chk("bnd_rdy", 32'(m0_ready), 32'd1);
        chk("bnd_err", 32'(m0_err),   32'd0);
`endif

        // Reset while BUSY_M1, then m0 wins a simultaneous request.
        start(1);
        step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b0, $urandom);
        #2 res = 1'b0;
        #1;
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_owner", 32'(owner),        32'd0);
        chk("rst_type",  32'(s_accessType), 32'd0);
        chk("rst_addr",  s_addr,            32'd0);
        model_reset();
        start(0);
        step(1'b1, 1'b1, $urandom);
        chk("rst_win", 32'(owner), 32'd0);
        drain();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 2; n++)
                if (!req_on[n] && $urandom_range(0, 2) == 0) start(n);
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
